// File: rtl/data_memory_responder.sv
// Data-memory responder: multi-cycle RV32 load/store into on-chip byte-addressed RAM.
// Optional DMEM_ACCESS_COUNT_EN adds READ_COUNT/WRITE_COUNT completion counters.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] READ_COUNT,
  output logic [31:0] WRITE_COUNT
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]    cnt;
  logic          lat_wr;
  logic [2:0]    lat_f3;
  logic [BW-1:0] lat_addr;
  logic [31:0]   lat_data;

  logic          req;
  logic          done;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   load_val;
  logic [31:0]   word;
  logic [1:0]    off;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  assign req  = MEM_READ | MEM_WRITE;
  assign done = (state == ACCESS) && (cnt == 4'd0);
  assign unused_addr = ^MEM_ADDRESS[31:BW];

  always_comb begin
    state_nx = state;
    BUSYWAIT = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = req;
        if (req) state_nx = ACCESS;
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        if (cnt == 4'd0) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Decode of the latched request; 'bad' also covers load-only codes used by stores.
  always_comb begin
    off      = lat_addr[1:0];
    word     = mem[lat_addr[BW-1:2]];
    byte_v   = 8'(word >> {off, 3'b000});
    half_v   = lat_addr[1] ? word[31:16] : word[15:0];
    bad      = 1'b1;
    be       = 4'b0000;
    wd       = lat_data;
    load_val = 32'd0;
    case (lat_f3)
      3'b000: begin
        bad      = 1'b0;
        load_val = {{24{byte_v[7]}}, byte_v};
        be       = 4'b0001 << off;
        wd       = {4{lat_data[7:0]}};
      end
      3'b001: begin
        bad      = off[0];
        load_val = {{16{half_v[15]}}, half_v};
        be       = lat_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{lat_data[15:0]}};
      end
      3'b010: begin
        bad      = (off != 2'b00);
        load_val = word;
        be       = 4'b1111;
      end
      3'b100: begin
        bad      = lat_wr;
        load_val = {24'd0, byte_v};
      end
      3'b101: begin
        bad      = lat_wr | off[0];
        load_val = {16'd0, half_v};
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      load_val = 32'd0;
      be       = 4'b0000;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= 4'd0;
      lat_wr     <= 1'b0;
      lat_f3     <= 3'd0;
      lat_addr   <= '0;
      lat_data   <= 32'd0;
      READ_DATA  <= 32'd0;
      MISALIGNED <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        lat_wr   <= MEM_WRITE;
        lat_f3   <= FUNC3;
        lat_addr <= MEM_ADDRESS[BW-1:0];
        lat_data <= MEM_WRITE_DATA;
        cnt      <= 4'(LATENCY - 1);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      MISALIGNED <= done & bad;
      if (done && !lat_wr) READ_DATA <= load_val;
    end
  end

  // Storage is never reset; reset forces IDLE so no commit can fire.
  always_ff @(posedge CLK) begin
    if (done && lat_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[lat_addr[BW-1:2]][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      READ_COUNT  <= 32'd0;
      WRITE_COUNT <= 32'd0;
    end else if (done) begin
      if (lat_wr) WRITE_COUNT <= WRITE_COUNT + 32'd1;
      else        READ_COUNT  <= READ_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: vector table plus reset/perturbation sequences.
// Build with DMEM_ACCESS_COUNT_EN to also check the access counters.
module tb_data_memory_responder;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] READ_COUNT;
  logic [31:0] WRITE_COUNT;
  int          exp_rc;
  int          exp_wc;
`endif

  int n_vec = 0;
  int n_bad = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(5)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .FUNC3          (FUNC3),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .READ_DATA      (READ_DATA),
    .BUSYWAIT       (BUSYWAIT),
    .MISALIGNED     (MISALIGNED)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .READ_COUNT     (READ_COUNT),
    .WRITE_COUNT    (WRITE_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vt[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic count_update(input logic wr, input logic rd);
`ifdef DMEM_ACCESS_COUNT_EN
    if (wr) exp_wc++;
    else if (rd) exp_rc++;
`else
    if (wr && rd) n_vec = n_vec + 0;
`endif
  endtask

  task automatic check_counts(input string tag);
`ifdef DMEM_ACCESS_COUNT_EN
    check({tag, " read_count"}, READ_COUNT, 32'(exp_rc));
    check({tag, " write_count"}, WRITE_COUNT, 32'(exp_wc));
`else
    if (tag == "") n_vec = n_vec + 0;
`endif
  endtask

  // One request from the CPU side; optionally disturbs inputs while in ACCESS.
  task automatic run_req(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic perturb, output int busy,
                         output logic [31:0] rdat, output logic mis,
                         output logic mis_after);
    @(negedge CLK);
    MEM_WRITE      = wr;
    MEM_READ       = rd;
    FUNC3          = f3;
    MEM_ADDRESS    = a;
    MEM_WRITE_DATA = d;
    #1;
    busy = 0;
    while (BUSYWAIT && busy < 40) begin
      busy++;
      @(negedge CLK);
      if (perturb && busy == 1) begin
        MEM_ADDRESS    = a ^ 32'h4;
        MEM_WRITE_DATA = ~d;
        FUNC3          = 3'b000;
      end
      #1;
    end
    rdat      = READ_DATA;
    mis       = MISALIGNED;
    MEM_WRITE = 1'b0;
    MEM_READ  = 1'b0;
    @(negedge CLK);
    #1;
    mis_after = MISALIGNED;
    count_update(wr, rd);
  endtask

  int          busy;
  logic [31:0] rdat;
  logic        mis;
  logic        mis_after;

  initial begin
    vt[0]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'b000, 32'h11,  32'hAAAAAA55, 32'h0000BEEF, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'b001, 32'h12,  32'hBBBB1234, 32'h0000BEEF, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h11,  32'h0,        32'h00000000, 1'b1};
    vt[10] = '{1'b1, 1'b0, 3'b001, 32'h13,  32'h0000FFFF, 32'h00000000, 1'b1};
    vt[11] = '{1'b0, 1'b1, 3'b010, 32'h10,  32'h0,        32'h123455EF, 1'b0};
    vt[12] = '{1'b1, 1'b0, 3'b010, 32'h400, 32'hA5A55A5A, 32'h123455EF, 1'b0};
    vt[13] = '{1'b0, 1'b1, 3'b010, 32'h0,   32'h0,        32'hA5A55A5A, 1'b0};
    vt[14] = '{1'b1, 1'b1, 3'b010, 32'h14,  32'h11223344, 32'hA5A55A5A, 1'b0};
    vt[15] = '{1'b0, 1'b1, 3'b010, 32'h14,  32'h0,        32'h11223344, 1'b0};
    vt[16] = '{1'b0, 1'b1, 3'b000, 32'h14,  32'h0,        32'h00000044, 1'b0};
    vt[17] = '{1'b0, 1'b1, 3'b011, 32'h10,  32'h0,        32'h00000000, 1'b1};
    vt[18] = '{1'b0, 1'b1, 3'b001, 32'h16,  32'h0,        32'h00001122, 1'b0};
    vt[19] = '{1'b1, 1'b0, 3'b000, 32'h17,  32'h00000080, 32'h00001122, 1'b0};
    vt[20] = '{1'b0, 1'b1, 3'b000, 32'h17,  32'h0,        32'hFFFFFF80, 1'b0};
    vt[21] = '{1'b1, 1'b0, 3'b010, 32'h20,  32'h01020304, 32'hFFFFFF80, 1'b0};

`ifdef DMEM_ACCESS_COUNT_EN
    exp_rc = 0;
    exp_wc = 0;
`endif
    RESET          = 1'b1;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    FUNC3          = 3'b000;
    MEM_ADDRESS    = 32'd0;
    MEM_WRITE_DATA = 32'd0;
    #1;
    check("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset read_data", READ_DATA, 32'd0);
    check("reset misaligned", {31'd0, MISALIGNED}, 32'd0);
    check_counts("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_req(vt[i].wr, vt[i].rd, vt[i].f3, vt[i].a, vt[i].d, 1'b0,
              busy, rdat, mis, mis_after);
      check($sformatf("v%0d busy_cycles", i), 32'(busy), 32'd6);
      check($sformatf("v%0d read_data", i), rdat, vt[i].exp_rd);
      check($sformatf("v%0d misaligned", i), {31'd0, mis}, {31'd0, vt[i].exp_mis});
      check($sformatf("v%0d mis_pulse_end", i), {31'd0, mis_after}, 32'd0);
      check_counts($sformatf("v%0d", i));
    end

    // Reset in the middle of a store aborts it.
    @(negedge CLK);
    MEM_WRITE      = 1'b1;
    FUNC3          = 3'b010;
    MEM_ADDRESS    = 32'h20;
    MEM_WRITE_DATA = 32'hCAFEF00D;
    @(negedge CLK);
    @(negedge CLK);
    RESET     = 1'b1;
    MEM_WRITE = 1'b0;
    #1;
    check("abort busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("abort read_data", READ_DATA, 32'd0);
    check("abort misaligned", {31'd0, MISALIGNED}, 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
    exp_rc = 0;
    exp_wc = 0;
`endif
    check_counts("abort");
    @(negedge CLK);
    RESET = 1'b0;
    run_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, busy, rdat, mis, mis_after);
    check("abort readback", rdat, 32'h01020304);
    check("abort readback busy", 32'(busy), 32'd6);

    // Inputs changed during ACCESS are ignored (load, then store).
    run_req(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b1, busy, rdat, mis, mis_after);
    check("perturb load data", rdat, 32'h123455EF);
    check("perturb load mis", {31'd0, mis}, 32'd0);
    run_req(1'b1, 1'b0, 3'b010, 32'h28, 32'hAABBCCDD, 1'b1, busy, rdat, mis, mis_after);
    check("perturb store busy", 32'(busy), 32'd6);
    run_req(1'b0, 1'b1, 3'b010, 32'h28, 32'h0, 1'b0, busy, rdat, mis, mis_after);
    check("perturb store target", rdat, 32'hAABBCCDD);
    run_req(1'b0, 1'b1, 3'b010, 32'h2C, 32'h0, 1'b0, busy, rdat, mis, mis_after);
    check("perturb store other", rdat === 32'h55443322 ? 32'd1 : 32'd0, 32'd0);
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
